fetch_pipe: RTL and testbench

FETCH_PIPE -- requirements
Module: fetch_pipe

---
 rtl/fetch_pipe.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_fetch_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pipe.sv
// -----------------------------------------------------------------------------
// fetch_pipe
//
// Fetch stage of a Y86-64 style pipeline together with its decode-stage
// pipeline register. Holds a byte-wide instruction memory, selects the fetch
// PC from the predicted PC or from late-stage redirects, splits and checks the
// instruction, predicts the next PC and loads the D register.
//
// Parameters
//   MEM_BYTES   byte size of the internal instruction memory
//   RESET_PC    first PC fetched after reset
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   imem_we/imem_waddr/imem_wdata byte write port into instruction memory
//   F_stall, D_stall, D_bubble    hazard controls from the pipeline control
//   M_icode, M_Cnd, M_valA        memory-stage feedback (mispredicted jXX)
//   W_icode, W_valM               write-back feedback (ret target)
//   D_stat .. D_valP              registered decode-stage pipeline register
//   f_pc                          combinational selected fetch PC
// -----------------------------------------------------------------------------
module fetch_pipe #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [63:0]        imem_waddr,
  input  logic [7:0]         imem_wdata,
  input  logic               F_stall,
  input  logic               D_stall,
  input  logic               D_bubble,
  input  logic [3:0]         M_icode,
  input  logic [0:0]         M_Cnd,
  input  logic [63:0]        M_valA,
  input  logic [3:0]         W_icode,
  input  logic [63:0]        W_valM,
  output logic [2:0]         D_stat,
  output logic [3:0]         D_icode,
  output logic [3:0]         D_ifun,
  output logic [3:0]         D_rA,
  output logic [3:0]         D_rB,
  output logic signed [63:0] D_valC,
  output logic [63:0]        D_valP,
  output logic [63:0]        f_pc
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  logic [7:0]  imem [MEM_BYTES];

  logic [63:0] pred_pc_q, pred_pc_d;
  logic        halted_q, halted_d;

  logic [2:0]  d_stat_q,  d_stat_d;
  logic [3:0]  d_icode_q, d_icode_d;
  logic [3:0]  d_ifun_q,  d_ifun_d;
  logic [3:0]  d_ra_q,    d_ra_d;
  logic [3:0]  d_rb_q,    d_rb_d;
  logic [63:0] d_valc_q,  d_valc_d;
  logic [63:0] d_valp_q,  d_valp_d;

  logic [63:0] byte_addr [10];
  logic [7:0]  fbyte [10];
  logic [9:0]  byte_in_range;
  logic [9:0]  byte_needed;

  logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_len;
  logic        f_instr_ok, f_has_regs, f_valc_at1, f_valc_at2, f_adr_err;
  logic [63:0] f_valC, f_valP, f_predPC;
  logic [2:0]  f_stat;
  logic        load_fetch;

  // Byte write port; the memory has no reset so program contents survive
  // a pipeline reset. A fetch in the same cycle reads the pre-write value.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < MEM_LIMIT)) begin
      imem[imem_waddr[AW-1:0]] <= imem_wdata;
    end
  end

  // A not-taken jXX reaching memory means the taken prediction was wrong,
  // so its fall-through PC wins; a ret in write-back supplies the return PC.
  always_comb begin
    if ((M_icode == I_JXX) && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end else begin
      f_pc = pred_pc_q;
    end
  end

  // Read the longest possible instruction (10 bytes). Addresses wrap at 64
  // bits; out-of-range bytes read as zero and are flagged for the ADR check.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      byte_addr[k]     = f_pc + 64'(k);
      byte_in_range[k] = (byte_addr[k] < MEM_LIMIT);
      fbyte[k]         = byte_in_range[k] ? imem[byte_addr[k][AW-1:0]] : 8'h00;
    end
  end

  // Split the first byte and work out length, operand layout and legality.
  always_comb begin
    f_icode    = fbyte[0][7:4];
    f_ifun     = fbyte[0][3:0];
    f_instr_ok = 1'b0;
    f_has_regs = 1'b0;
    f_valc_at1 = 1'b0;
    f_valc_at2 = 1'b0;
    f_len      = 4'd1;
    case (f_icode)
      I_HALT, I_NOP, I_RET: begin
        f_len      = 4'd1;
        f_instr_ok = (f_ifun == 4'd0);
      end
      I_RRMOVQ: begin
        f_len      = 4'd2;
        f_has_regs = 1'b1;
        f_instr_ok = (f_ifun <= 4'd6);
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        f_len      = 4'd10;
        f_has_regs = 1'b1;
        f_valc_at2 = 1'b1;
        f_instr_ok = (f_ifun == 4'd0);
      end
      I_OPQ: begin
        f_len      = 4'd2;
        f_has_regs = 1'b1;
        f_instr_ok = (f_ifun <= 4'd3);
      end
      I_JXX: begin
        f_len      = 4'd9;
        f_valc_at1 = 1'b1;
        f_instr_ok = (f_ifun <= 4'd6);
      end
      I_CALL: begin
        f_len      = 4'd9;
        f_valc_at1 = 1'b1;
        f_instr_ok = (f_ifun == 4'd0);
      end
      I_PUSHQ, I_POPQ: begin
        f_len      = 4'd2;
        f_has_regs = 1'b1;
        f_instr_ok = (f_ifun == 4'd0);
      end
      default: begin
        // Unknown opcodes occupy only their first byte.
        f_len      = 4'd1;
        f_instr_ok = 1'b0;
      end
    endcase
  end

  // Only bytes that belong to the instruction can raise an address error.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      byte_needed[k] = (4'(k) < f_len);
    end
  end

  assign f_adr_err = |(byte_needed & ~byte_in_range);

  // Operand fields, sequential PC, next-PC prediction (jumps/calls assumed
  // taken) and status, with address errors ranked above illegal encodings.
  always_comb begin
    f_rA = f_has_regs ? fbyte[1][7:4] : REG_NONE;
    f_rB = f_has_regs ? fbyte[1][3:0] : REG_NONE;

    if (f_valc_at2) begin
      f_valC = {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
    end else if (f_valc_at1) begin
      f_valC = {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
    end else begin
      f_valC = 64'd0;
    end

    f_valP   = f_pc + {60'd0, f_len};
    f_predPC = f_valc_at1 ? f_valC : f_valP;

    if (f_adr_err) begin
      f_stat = STAT_ADR;
    end else if (!f_instr_ok) begin
      f_stat = STAT_INS;
    end else if (f_icode == I_HALT) begin
      f_stat = STAT_HLT;
    end else begin
      f_stat = STAT_AOK;
    end
  end

  assign load_fetch = !D_stall && !D_bubble && !halted_q;

  // Predicted PC freezes on a fetch stall and for good once halted.
  always_comb begin
    pred_pc_d = pred_pc_q;
    if (!F_stall && !halted_q) begin
      pred_pc_d = f_predPC;
    end
  end

  // halted latches when a non-AOK instruction actually enters D.
  assign halted_d = halted_q | (load_fetch && (f_stat != STAT_AOK));

  // D register next state. Stall beats everything; after a halt the stage
  // keeps issuing bubbles that carry the stopping instruction's status.
  always_comb begin
    d_stat_d  = d_stat_q;
    d_icode_d = d_icode_q;
    d_ifun_d  = d_ifun_q;
    d_ra_d    = d_ra_q;
    d_rb_d    = d_rb_q;
    d_valc_d  = d_valc_q;
    d_valp_d  = d_valp_q;
    if (!D_stall) begin
      if (halted_q || D_bubble || (f_stat == STAT_ADR) || (f_stat == STAT_INS)) begin
        if (halted_q) begin
          d_stat_d = d_stat_q;
        end else if (D_bubble) begin
          d_stat_d = STAT_AOK;
        end else begin
          d_stat_d = f_stat;
        end
        d_icode_d = I_NOP;
        d_ifun_d  = 4'd0;
        d_ra_d    = REG_NONE;
        d_rb_d    = REG_NONE;
        d_valc_d  = 64'd0;
        d_valp_d  = 64'd0;
      end else begin
        d_stat_d  = f_stat;
        d_icode_d = f_icode;
        d_ifun_d  = f_ifun;
        d_ra_d    = f_rA;
        d_rb_d    = f_rB;
        d_valc_d  = f_valC;
        d_valp_d  = f_valP;
      end
    end
  end

  // Reset restarts fetch at RESET_PC with a bubble in D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
      halted_q  <= 1'b0;
      d_stat_q  <= STAT_AOK;
      d_icode_q <= I_NOP;
      d_ifun_q  <= 4'd0;
      d_ra_q    <= REG_NONE;
      d_rb_q    <= REG_NONE;
      d_valc_q  <= 64'd0;
      d_valp_q  <= 64'd0;
    end else begin
      pred_pc_q <= pred_pc_d;
      halted_q  <= halted_d;
      d_stat_q  <= d_stat_d;
      d_icode_q <= d_icode_d;
      d_ifun_q  <= d_ifun_d;
      d_ra_q    <= d_ra_d;
      d_rb_q    <= d_rb_d;
      d_valc_q  <= d_valc_d;
      d_valp_q  <= d_valp_d;
    end
  end

  assign D_stat  = d_stat_q;
  assign D_icode = d_icode_q;
  assign D_ifun  = d_ifun_q;
  assign D_rA    = d_ra_q;
  assign D_rB    = d_rb_q;
  assign D_valC  = d_valc_q;
  assign D_valP  = d_valp_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// -----------------------------------------------------------------------------
// tb_fetch_pipe
//
// Directed scenarios followed by a randomized run of fetch_pipe, each cycle
// compared against a behavioural model of the instruction set's encoding
// rules (byte table lookups, little-endian accumulation) held in the bench.
// -----------------------------------------------------------------------------
module tb_fetch_pipe;

  localparam int          MEMB = 1024;
  localparam logic [63:0] RPC  = 64'd0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_we;
  logic [63:0]        imem_waddr;
  logic [7:0]         imem_wdata;
  logic               F_stall, D_stall, D_bubble;
  logic [3:0]         M_icode;
  logic [0:0]         M_Cnd;
  logic [63:0]        M_valA;
  logic [3:0]         W_icode;
  logic [63:0]        W_valM;
  logic [2:0]         D_stat;
  logic [3:0]         D_icode, D_ifun, D_rA, D_rB;
  logic signed [63:0] D_valC;
  logic [63:0]        D_valP;
  logic [63:0]        f_pc;

  fetch_pipe #(.MEM_BYTES(MEMB), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .f_pc(f_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } dreg_t;

  // Instruction length per opcode (unknown opcodes take one byte) and the
  // highest legal function code per opcode (-1: opcode itself illegal).
  int lenOf [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int maxFn [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

  logic [7:0]  refMem [MEMB];
  logic [63:0] refPred;
  bit          refHalted;
  dreg_t       refD;

  int vecCount  = 0;
  int missCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic dreg_t bubbleOf(input logic [2:0] st);
    dreg_t b;
    b.stat = st; b.icode = 4'h1; b.ifun = 4'h0; b.rA = 4'hF; b.rB = 4'hF;
    b.valC = 64'd0; b.valP = 64'd0;
    return b;
  endfunction

  function automatic logic [7:0] refByte(input logic [63:0] a);
    if (a < 64'(MEMB)) return refMem[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [63:0] selPc();
    if (M_icode == 4'h7 && M_Cnd == 1'b0) return M_valA;
    if (W_icode == 4'h9) return W_valM;
    return refPred;
  endfunction

  // Decode one instruction at pc straight from the encoding rules.
  function automatic void refFetch(input logic [63:0] pc, output dreg_t d, output logic [63:0] nextPc);
    logic [7:0]  b0, b1;
    logic [63:0] c;
    int          ic, fn, len;
    bit          adr;
    b0  = refByte(pc);
    b1  = refByte(pc + 64'd1);
    ic  = int'(b0[7:4]);
    fn  = int'(b0[3:0]);
    len = lenOf[ic];
    adr = 0;
    for (int k = 0; k < len; k++) begin
      if (pc + 64'(k) >= 64'(MEMB)) adr = 1;
    end
    c = 64'd0;
    if (ic >= 3 && ic <= 5) begin
      for (int k = 0; k < 8; k++) c = c | (64'(refByte(pc + 64'(2 + k))) << (8 * k));
    end else if (ic == 7 || ic == 8) begin
      for (int k = 0; k < 8; k++) c = c | (64'(refByte(pc + 64'(1 + k))) << (8 * k));
    end
    d.icode = b0[7:4];
    d.ifun  = b0[3:0];
    if (ic == 2 || (ic >= 3 && ic <= 6) || ic == 10 || ic == 11) begin
      d.rA = b1[7:4];
      d.rB = b1[3:0];
    end else begin
      d.rA = 4'hF;
      d.rB = 4'hF;
    end
    d.valC = c;
    d.valP = pc + 64'(len);
    nextPc = (ic == 7 || ic == 8) ? c : d.valP;
    if (adr)              d.stat = 3'd3;
    else if (fn > maxFn[ic]) d.stat = 3'd4;
    else if (ic == 0)     d.stat = 3'd2;
    else                  d.stat = 3'd1;
    if (d.stat == 3'd3 || d.stat == 3'd4) d = bubbleOf(d.stat);
  endfunction

  task automatic refReset();
    refPred   = RPC;
    refHalted = 0;
    refD      = bubbleOf(3'd1);
  endtask

  task automatic checkD(input string tag);
    checkOutput({tag, ".stat"},  64'(D_stat),  64'(refD.stat));
    checkOutput({tag, ".icode"}, 64'(D_icode), 64'(refD.icode));
    checkOutput({tag, ".ifun"},  64'(D_ifun),  64'(refD.ifun));
    checkOutput({tag, ".rA"},    64'(D_rA),    64'(refD.rA));
    checkOutput({tag, ".rB"},    64'(D_rB),    64'(refD.rB));
    checkOutput({tag, ".valC"},  D_valC,       refD.valC);
    checkOutput({tag, ".valP"},  D_valP,       refD.valP);
  endtask

  task automatic applyStimulus(input bit fs, input bit ds, input bit db,
                               input logic [3:0] mi, input bit mc, input logic [63:0] ma,
                               input logic [3:0] wi, input logic [63:0] wm);
    F_stall = fs; D_stall = ds; D_bubble = db;
    M_icode = mi; M_Cnd = mc; M_valA = ma;
    W_icode = wi; W_valM = wm;
  endtask

  task automatic quiet();
    applyStimulus(0, 0, 0, 4'h0, 1'b1, 64'd0, 4'h0, 64'd0);
    imem_we = 1'b0;
  endtask

  // One clock cycle from negedge to negedge: check f_pc, advance the model
  // at the rising edge, then check the D register.
  task automatic stepCycle();
    logic [63:0] expPc, nxt;
    dreg_t       fd;
    bit          haltNow;
    haltNow = 0;
    #1;
    expPc = selPc();
    checkOutput("f_pc", f_pc, expPc);
    refFetch(expPc, fd, nxt);
    @(posedge clk);
    if (!D_stall) begin
      if (refHalted) refD = bubbleOf(refD.stat);
      else if (D_bubble) refD = bubbleOf(3'd1);
      else begin
        refD = fd;
        if (fd.stat != 3'd1) haltNow = 1;
      end
    end
    if (!F_stall && !refHalted) refPred = nxt;
    if (haltNow) refHalted = 1;
    if (imem_we && imem_waddr < 64'(MEMB)) refMem[int'(imem_waddr)] = imem_wdata;
    #1;
    checkD("D");
    @(negedge clk);
  endtask

  // Memory load while the pipeline sits in reset.
  task automatic loadByte(input int addr, input logic [7:0] data);
    imem_we    = 1'b1;
    imem_waddr = 64'(addr);
    imem_wdata = data;
    @(posedge clk);
    refMem[addr] = data;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic enterReset();
    rst_n = 1'b0;
    refReset();
  endtask

  // Asynchronous reset between edges: D must bubble without waiting for clk.
  task automatic pulseReset(input string tag);
    quiet();
    #2 rst_n = 1'b0;
    #1;
    refReset();
    checkD(tag);
    checkOutput({tag, ".f_pc"}, f_pc, RPC);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          haltAge;
    int          r, ic, fn, pc;
    logic [63:0] v, tgt;
    logic [7:0]  prog [MEMB];

    rst_n      = 1'b0;
    imem_waddr = 64'd0;
    imem_wdata = 8'h00;
    quiet();
    refReset();
    @(negedge clk);
    #1;
    checkD("reset");
    checkOutput("reset.f_pc", f_pc, RPC);

    for (int a = 0; a < MEMB; a++) loadByte(a, 8'h10);

    // irmovq $10,%rsp followed by a nop
    loadByte(0, 8'h30); loadByte(1, 8'hF4); loadByte(2, 8'h0A);
    for (int a = 3; a < 10; a++) loadByte(a, 8'h00);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("irmovq.icode", 64'(D_icode), 64'd3);
    checkOutput("irmovq.rB",    64'(D_rB),    64'd4);
    checkOutput("irmovq.valC",  D_valC,       64'd10);
    checkOutput("irmovq.valP",  D_valP,       64'd10);
    stepCycle();
    checkOutput("nop.icode", 64'(D_icode), 64'd1);
    checkOutput("nop.valP",  D_valP,       64'd11);

    // jXX predicted taken to 0x20, then corrected by memory stage to 9
    enterReset();
    loadByte(0, 8'h74); loadByte(1, 8'h20);
    for (int a = 2; a < 9; a++) loadByte(a, 8'h00);
    loadByte(9, 8'h10);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("jxx.icode", 64'(D_icode), 64'd7);
    checkOutput("jxx.valC",  D_valC,       64'h20);
    applyStimulus(0, 0, 0, 4'h7, 1'b0, 64'd9, 4'h0, 64'd0);
    #1 checkOutput("jxx.redirect", f_pc, 64'd9);
    stepCycle();
    checkOutput("jxx.fix.valP", D_valP, 64'd10);
    quiet();

    // stalls hold, lone bubble inserts a nop
    enterReset();
    for (int a = 0; a < 16; a++) loadByte(a, 8'h10);
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(1, 1, 0, 4'h0, 1'b1, 64'd0, 4'h0, 64'd0);
    stepCycle();
    stepCycle();
    checkOutput("stall.valP", D_valP, 64'd1);
    applyStimulus(0, 0, 1, 4'h0, 1'b1, 64'd0, 4'h0, 64'd0);
    stepCycle();
    checkOutput("bubble.icode", 64'(D_icode), 64'd1);
    checkOutput("bubble.stat",  64'(D_stat),  64'd1);
    checkOutput("bubble.valP",  D_valP,       64'd0);
    quiet();
    stepCycle();

    // illegal opcode and halt both freeze the stage
    enterReset();
    loadByte(0, 8'hC0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("ins.stat",  64'(D_stat),  64'd4);
    checkOutput("ins.icode", 64'(D_icode), 64'd1);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("ins.hold", 64'(D_stat), 64'd4);
    enterReset();
    loadByte(0, 8'h00);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("hlt.stat", 64'(D_stat), 64'd2);
    stepCycle();
    stepCycle();
    checkOutput("hlt.hold",  64'(D_stat),  64'd2);
    checkOutput("hlt.icode", 64'(D_icode), 64'd1);

    // instruction running off the end of memory, then a mid-run reset
    enterReset();
    loadByte(0, 8'h10);
    loadByte(MEMB - 2, 8'h30); loadByte(MEMB - 1, 8'hF4);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 4'h0, 1'b1, 64'd0, 4'h9, 64'(MEMB - 2));
    stepCycle();
    checkOutput("adr.stat",  64'(D_stat),  64'd3);
    checkOutput("adr.icode", 64'(D_icode), 64'd1);
    quiet();
    stepCycle();
    pulseReset("midrst");
    stepCycle();
    checkOutput("refetch.icode", 64'(D_icode), 64'd1);
    checkOutput("refetch.valP",  D_valP,       64'd1);

    // randomized program and control traffic
    enterReset();
    pc = 0;
    while (pc < MEMB) begin
      r = $urandom_range(0, 99);
      if (r < 2) ic = 0;
      else if (r < 4) ic = $urandom_range(12, 15);
      else ic = $urandom_range(1, 11);
      fn = (maxFn[ic] > 0) ? $urandom_range(0, maxFn[ic]) : 0;
      if ($urandom_range(0, 19) == 0) fn = $urandom_range(0, 15);
      v = {$urandom, $urandom};
      if (ic == 7 || ic == 8) v = 64'($urandom_range(0, MEMB - 1));
      for (int k = 0; k < lenOf[ic] && pc + k < MEMB; k++) begin
        if (k == 0) prog[pc] = 8'(ic * 16 + fn);
        else if (k == 1 && !(ic == 7 || ic == 8)) prog[pc + k] = 8'($urandom);
        else if (ic == 7 || ic == 8) prog[pc + k] = v[8*(k-1) +: 8];
        else prog[pc + k] = v[8*(k-2) +: 8];
      end
      pc += lenOf[ic];
    end
    for (int a = 0; a < MEMB; a++) loadByte(a, prog[a]);
    rst_n   = 1'b1;
    haltAge = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ((refHalted && haltAge > 2) || $urandom_range(0, 99) == 0) begin
        pulseReset("rndrst");
        haltAge = 0;
      end
      r = $urandom_range(0, 19);
      if (r == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else if (r < 3) tgt = 64'(MEMB - 6 + $urandom_range(0, 10));
      else tgt = 64'($urandom_range(0, MEMB - 1));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0,
                    ($urandom_range(0, 11) == 0) ? 4'h7 : 4'($urandom_range(0, 6)),
                    1'b0, tgt,
                    ($urandom_range(0, 11) == 0) ? 4'h9 : 4'($urandom_range(0, 8)),
                    64'($urandom_range(0, MEMB + 4)));
      imem_we    = ($urandom_range(0, 7) == 0);
      imem_waddr = 64'($urandom_range(0, MEMB + 7));
      imem_wdata = 8'($urandom);
      stepCycle();
      if (refHalted) haltAge++;
    end
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
